mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit RAM port among the CPU instruction fetch, stack/data accesses (PUSH/POP/CALL/RET, MOV mem) and the I/O block.
- Issues one memory transaction at a time and sequences it through a fixed RAM latency.
- Returns a one-cycle per-requester bus_ready pulse, which cpu_ctrl consumes to leave its RAM-wait states.

Parameters:
- NUM_REQ, 3: number of requesters; index 0 = CPU fetch, 1 = stack/data, 2 = I/O.
- ADDR_W, 8: address width.
- DATA_W, 8: data width.
- RAM_LAT, 2: cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_cycle  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transaction request; level, held until bus_ready.
- we  in  NUM_REQ  per-requester write enable, qualified by req.
- addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot grant, high ACCESS through DONE.
- bus_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  DATA_W  registered read data, valid while bus_ready is high, held until the next read completes.
- mem_en  out  1  RAM access strobe, one cycle.
- mem_we  out  1  RAM write strobe, only together with mem_en.
- mem_addr  out  ADDR_W  RAM address, latched for the whole transaction.
- mem_wdata  out  DATA_W  RAM write data, latched.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, reset_cycle=1 at a rising edge):
  - state=IDLE; gnt, bus_ready, mem_en, mem_we, busy = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction aborts it silently: no bus_ready is issued and the RAM is left idle.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req is high, pick the winner by round robin: first requester with req high, searching from last+1 and wrapping at NUM_REQ-1 -> 0.
  - Latch winner index, addr, wdata and we; go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle): mem_en=1, mem_we=latched we, gnt[winner]=1, last<=winner. Load wait counter with RAM_LAT-1, then go to WAIT.
- WAIT (RAM_LAT cycles):
  - Counter decrements each cycle; leave when it reaches 0.
  - On the final WAIT edge, rdata<=mem_rdata if the transaction is a read; writes leave rdata unchanged. Then go to DONE.
- DONE (1 cycle): bus_ready[winner]=1, gnt held.
  - Arbitrate as in IDLE, with req[winner] masked for this cycle only, because the requester is still holding req while it sees bus_ready.
  - Any remaining request -> ACCESS next cycle with the new winner latched. Otherwise -> IDLE.
- Latency from req seen in IDLE to bus_ready is RAM_LAT+2 cycles (4 at default). Back-to-back throughput is one transaction per RAM_LAT+2 cycles.
- A requester dropping req after being latched does not cancel the transaction. It completes and bus_ready still pulses; the requester ignores it.
- addr, wdata and we changes after latching are ignored.
- Non-winner requests are never lost: they stay pending as long as req stays high. Round robin bounds the wait to NUM_REQ-1 transactions.
- Width rules: addresses and data pass through unmodified. The wait counter is 4 bits.

Optional Feature:
- Macro MEM_ARB_LOCK_EN.
- Defined: adds input port lock (NUM_REQ bits).
  - If lock[winner]=1 and req[winner]=1 in DONE, the winner is re-granted next cycle, bypassing the DONE mask and round robin. This makes CALL's push-then-jump sequence atomic.
  - The last pointer is not advanced while the lock is held.
- Undefined: port absent; pure round robin.

Decomposition:
- mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, ACCESS, WAIT, DONE};
  - requester index constants REQ_CPU=0, REQ_STACK=1, REQ_IO=2;
  - default RAM_LAT.
- Sub-module rr_pick (combinational): inputs req, mask, last; outputs one-hot pick and valid. It is instantiated once and used in both IDLE and DONE arbitration.

Test Plan:
- Read from req[0], addr=0x10, RAM returns 0xA5 after 2 cycles:
  - mem_en/mem_addr=0x10 at t1; gnt[0] high t1..t4; bus_ready[0] only at t4; rdata=0xA5 at t4.
- Write from req[1], addr=0x20, wdata=0x3C:
  - mem_en=mem_we=1 with addr 0x20/data 0x3C at t1 only; bus_ready[1] at t4; rdata keeps its previous value.
- req[2:0]=3'b111 held, each requester dropping req the cycle after its bus_ready:
  - grant order 0,1,2 with ACCESS at t1, t5, t9; no idle cycle between transactions.
- reset_cycle pulsed during WAIT:
  - next cycle state IDLE, all outputs 0, no bus_ready for the aborted transaction.
- req[0] dropped during WAIT:
  - bus_ready[0] still pulses at t4; the arbiter then returns to IDLE with busy=0.
- With MEM_ARB_LOCK_EN, req=3'b011, lock[0]=1 for two transactions:
  - requester 0 granted twice consecutively, then requester 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// Requester indices match the bit positions of req/gnt/bus_ready.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } arb_state_t;

    localparam int REQ_CPU   = 0;
    localparam int REQ_STACK = 1;
    localparam int REQ_IO    = 2;

    localparam int RAM_LAT_DEF = 2;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request after last.
// Output is one-hot; valid is low when nothing is eligible.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   k;

    assign cand = req & ~mask;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        k     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!valid && cand[k]) begin
                pick[k] = 1'b1;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one RAM port, one transaction at a time.
// Build with MEM_ARB_LOCK_EN to add the lock input for atomic sequences.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = RAM_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      reset_cycle,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        bus_ready,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic               relock;
    logic               relock_now;
    logic               go;
    logic               we_q;
    logic [3:0]         cnt;

    assign win_oh = NUM_REQ'(1) << win;

    // The finishing requester still holds req while it sees bus_ready.
    assign mask = (state == DONE) ? win_oh : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .mask  (mask),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

`ifdef MEM_ARB_LOCK_EN
    assign relock_now = (state == DONE) && lock[win] && req[win];
`else
    assign relock_now = 1'b0;
`endif

    assign sel_idx = relock_now ? win : pick_idx;
    assign go      = relock_now || pick_valid;

    assign busy      = (state != IDLE);
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign gnt       = busy ? win_oh : '0;
    assign bus_ready = (state == DONE) ? win_oh : '0;

    always_ff @(posedge clk) begin
        if (reset_cycle) begin
            state     <= IDLE;
            win       <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
            relock    <= 1'b0;
            we_q      <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    relock <= relock_now;
                    if (go) begin
                        win       <= sel_idx;
                        we_q      <= we[sel_idx];
                        mem_addr  <= addr[sel_idx*ADDR_W +: ADDR_W];
                        mem_wdata <= wdata[sel_idx*DATA_W +: DATA_W];
                        state     <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    // A locked re-grant keeps the rotation where it was.
                    if (!relock) last <= win;
                    cnt   <= 4'(RAM_LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (!we_q) rdata <= mem_rdata;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
